read_src_fsm: RTL and testbench

READ_SRC_FSM -- requirements
Module: read_src_fsm

---
 rtl/dma_pkg.sv | 47 ++++
 rtl/dma_fifo_if.sv | 12 +
 rtl/ofs_plat_axi_mem_if.sv | 44 ++++
 rtl/read_src_fsm.sv | 130 +++++++++++++
 tb/tb_read_src_fsm.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dma_pkg.sv
// Shared DMA types: descriptor, CSR control/status, read-FSM state encoding and AXI codes.
// No logic; widths here size the address, length and counter paths of the read engine.
package dma_pkg;

    localparam int SRC_ADDR_W  = 64;
    localparam int LENGTH_W    = 20;
    localparam int PERF_CNTR_W = 32;
    localparam int RD_STATE_W  = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic [RD_STATE_W-1:0] {
        IDLE           = 4'b0001,
        ADDR_SETUP     = 4'b0010,
        RD_SRC_WR_FIFO = 4'b0100,
        ERROR          = 4'b1000
    } t_rd_state;

    typedef struct packed {
        logic       go;
        logic [1:0] mode;
    } t_dma_descriptor_control;

    typedef struct packed {
        logic [SRC_ADDR_W-1:0]   src_addr;
        logic [LENGTH_W-1:0]     length;
        t_dma_descriptor_control descriptor_control;
    } t_dma_descriptor;

    typedef struct packed {
        logic reset_dispatcher;
    } t_dma_csr_control;

    typedef struct packed {
        logic                   busy;
        logic [RD_STATE_W-1:0]  rd_state;
        logic                   stopped_on_error;
        logic                   rd_rsp_err;
        logic [PERF_CNTR_W-1:0] clk_cnt;
        logic [PERF_CNTR_W-1:0] valid_cnt;
    } t_dma_csr_status_rd;

endpackage

// File: rtl/dma_fifo_if.sv
// Write side of the DMA data FIFO; wr_in is the producer view.
interface dma_fifo_if #(
    parameter int DATA_W = 512
);
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              almost_full;
    logic              not_full;

    modport wr_in  (output wr_en, wr_data, input almost_full, not_full);
    modport wr_out (input wr_en, wr_data, output almost_full, not_full);
endinterface

// File: rtl/ofs_plat_axi_mem_if.sv
// AXI memory port bundle; to_sink is the master side that issues requests.
interface ofs_plat_axi_mem_if #(
    parameter int ADDR_W = dma_pkg::SRC_ADDR_W,
    parameter int DATA_W = 512,
    parameter int ID_W   = 4
);
    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
    } t_axi_ar;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
    } t_axi_r;

    logic    arvalid;
    logic    arready;
    t_axi_ar ar;
    logic    rvalid;
    logic    rready;
    t_axi_r  r;
    logic    awvalid;
    logic    awready;
    logic    wvalid;
    logic    wready;
    logic    bvalid;
    logic    bready;

    modport to_sink (
        output arvalid, ar, rready, awvalid, wvalid, bready,
        input  arready, rvalid, r, awready, wready, bvalid
    );

    modport to_source (
        input  arvalid, ar, rready, awvalid, wvalid, bready,
        output arready, rvalid, r, awready, wready, bvalid
    );
endinterface

// File: rtl/read_src_fsm.sv
// Splits a descriptor into AXI read bursts (one AR outstanding) and streams R beats into the FIFO.
// Beats pass combinationally from R to the FIFO; almost_full deasserts rready, error beats are dropped.
module read_src_fsm
    import dma_pkg::*;
#(
    parameter int DATA_W          = 512,
    parameter int MAX_BURST_BEATS = 256
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 descriptor_fifo_not_empty,
    input  t_dma_descriptor      descriptor,
    input  t_dma_csr_control     csr_control,
    output logic                 rd_fsm_done,
    output t_dma_csr_status_rd   rd_src_status,
    ofs_plat_axi_mem_if.to_sink  src_mem,
    dma_fifo_if.wr_in            wr_fifo_if
);
    localparam int                    BEAT_BYTES   = DATA_W / 8;
    localparam logic [SRC_ADDR_W-1:0] BURST_STRIDE = SRC_ADDR_W'(MAX_BURST_BEATS * BEAT_BYTES);
    localparam logic [LENGTH_W:0]     MAX_BEATS    = (LENGTH_W + 1)'(MAX_BURST_BEATS);
    localparam logic [2:0]            AR_SIZE      = 3'($clog2(BEAT_BYTES));

    t_rd_state              state;
    t_rd_state              state_nxt;
    logic [SRC_ADDR_W-1:0]  araddr;
    logic [LENGTH_W:0]      remaining;
    logic [LENGTH_W:0]      num_bursts;
    logic [LENGTH_W:0]      burst_cnt;
    logic [PERF_CNTR_W-1:0] clk_cnt;
    logic [PERF_CNTR_W-1:0] valid_cnt;

    logic              go_vld;
    logic              len_zero;
    logic              rd_rdy;
    logic              beat_acc;
    logic              beat_err;
    logic              last_ok;
    logic              more_bursts;
    logic [LENGTH_W:0] burst_beats;

    assign go_vld      = (state == IDLE) && descriptor.descriptor_control.go && descriptor_fifo_not_empty;
    assign len_zero    = (descriptor.length == '0);
    // Reset gating keeps the reset cycle free of FIFO writes and R handshakes.
    assign rd_rdy      = reset_n && (((state == RD_SRC_WR_FIFO) && !wr_fifo_if.almost_full) ||
                                     (state == ERROR));
    assign beat_acc    = src_mem.rvalid && rd_rdy;
    assign beat_err    = beat_acc && ((src_mem.r.resp == RESP_SLVERR) || (src_mem.r.resp == RESP_DECERR));
    assign last_ok     = beat_acc && !beat_err && src_mem.r.last && (state == RD_SRC_WR_FIFO);
    assign more_bursts = (burst_cnt + 1'b1) < num_bursts;
    assign burst_beats = (remaining < MAX_BEATS) ? remaining : MAX_BEATS;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:           if (go_vld && !len_zero) state_nxt = ADDR_SETUP;
            ADDR_SETUP:     if (src_mem.arready) state_nxt = RD_SRC_WR_FIFO;
            RD_SRC_WR_FIFO: begin
                if (beat_err)     state_nxt = ERROR;
                else if (last_ok) state_nxt = more_bursts ? ADDR_SETUP : IDLE;
            end
            ERROR:          if (csr_control.reset_dispatcher) state_nxt = IDLE;
            default:        state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            araddr     <= '0;
            remaining  <= '0;
            num_bursts <= '0;
            burst_cnt  <= '0;
            clk_cnt    <= '0;
            valid_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (go_vld && !len_zero) begin
                araddr     <= descriptor.src_addr;
                remaining  <= {1'b0, descriptor.length};
                num_bursts <= ({1'b0, descriptor.length} + (MAX_BEATS - 1'b1)) / MAX_BEATS;
                burst_cnt  <= '0;
                clk_cnt    <= '0;
                valid_cnt  <= '0;
            end
            if (state == RD_SRC_WR_FIFO) begin
                clk_cnt <= clk_cnt + 1'b1;
                if (beat_acc) begin
                    remaining <= remaining - 1'b1;
                    valid_cnt <= valid_cnt + 1'b1;
                end
                if (last_ok && more_bursts) begin
                    burst_cnt <= burst_cnt + 1'b1;
                    araddr    <= araddr + BURST_STRIDE;
                end
            end
        end
    end

    always_comb begin
        src_mem.arvalid  = reset_n && (state == ADDR_SETUP);
        src_mem.ar       = '0;
        src_mem.ar.addr  = araddr;
        src_mem.ar.len   = 8'(burst_beats - 1'b1);
        src_mem.ar.size  = AR_SIZE;
        src_mem.ar.burst = BURST_INCR;
        src_mem.rready   = rd_rdy;
        src_mem.awvalid  = 1'b0;
        src_mem.wvalid   = 1'b0;
        src_mem.bready   = 1'b1;

        wr_fifo_if.wr_en   = beat_acc && !beat_err && (state == RD_SRC_WR_FIFO);
        wr_fifo_if.wr_data = src_mem.r.data;

        rd_fsm_done = reset_n && ((go_vld && len_zero) || (last_ok && !more_bursts));

        rd_src_status                  = '0;
        rd_src_status.busy             = (state != IDLE);
        rd_src_status.rd_state         = state;
        rd_src_status.stopped_on_error = (state == ERROR);
        rd_src_status.rd_rsp_err       = (state == ERROR);
        rd_src_status.clk_cnt          = clk_cnt;
        rd_src_status.valid_cnt        = valid_cnt;
    end

    logic unused_ok;
    assign unused_ok = &{1'b0, descriptor.descriptor_control.mode, wr_fifo_if.not_full,
                         src_mem.awready, src_mem.wready, src_mem.bvalid, src_mem.r.id};

endmodule

// File: tb/tb_read_src_fsm.sv
// Directed bench for read_src_fsm with a small AXI read slave and a FIFO write monitor.
module tb_read_src_fsm;
    import dma_pkg::*;

    localparam int DATA_W = 512;
    localparam int MAXB   = 256;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               descriptor_fifo_not_empty = 1'b0;
    logic               rd_fsm_done;
    t_dma_descriptor    descriptor;
    t_dma_csr_control   csr_control;
    t_dma_csr_status_rd rd_src_status;

    ofs_plat_axi_mem_if #(.ADDR_W(SRC_ADDR_W), .DATA_W(DATA_W)) src_mem ();
    dma_fifo_if #(.DATA_W(DATA_W)) wr_fifo_if ();

    read_src_fsm #(.DATA_W(DATA_W), .MAX_BURST_BEATS(MAXB)) dut (
        .clk                       (clk),
        .reset_n                   (reset_n),
        .descriptor_fifo_not_empty (descriptor_fifo_not_empty),
        .descriptor                (descriptor),
        .csr_control               (csr_control),
        .rd_fsm_done               (rd_fsm_done),
        .rd_src_status             (rd_src_status),
        .src_mem                   (src_mem),
        .wr_fifo_if                (wr_fifo_if)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          wr_cnt, ar_cnt, done_cnt, done_wr;
    logic [63:0] exp_data;
    logic [63:0] ar_addr_log [8];
    int          ar_len_log [8];
    int          err_idx = -1;
    bit          af_rand = 1'b0;
    int          s_beats_left = 0;
    int          s_data_idx = 0;
    bit          ar_hs, r_hs, rst_s;
    logic [7:0]  ar_len_hs;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // AXI read slave (drives at posedge+1) and monitors (sample at negedge).
    initial begin : bfm
        src_mem.arready = 1'b0;
        src_mem.rvalid  = 1'b0;
        src_mem.r       = '0;
        src_mem.awready = 1'b0;
        src_mem.wready  = 1'b0;
        src_mem.bvalid  = 1'b0;
        forever begin
            @(negedge clk);
            ar_hs = src_mem.arvalid && src_mem.arready;
            r_hs  = src_mem.rvalid && src_mem.rready;
            rst_s = !reset_n;
            if (!reset_n) check("wr_en_in_reset", 64'(wr_fifo_if.wr_en), 64'd0);
            if (ar_hs) begin
                if (ar_cnt < 8) begin
                    ar_addr_log[ar_cnt] = src_mem.ar.addr;
                    ar_len_log[ar_cnt]  = int'(src_mem.ar.len);
                end
                ar_cnt++;
                ar_len_hs = src_mem.ar.len;
                check("arsize", 64'(src_mem.ar.size), 64'd6);
                check("arburst", 64'(src_mem.ar.burst), 64'(BURST_INCR));
                check("arid", 64'(src_mem.ar.id), 64'd0);
            end
            if (wr_fifo_if.wr_en) begin
                check("wr_data", wr_fifo_if.wr_data[63:0], exp_data);
                exp_data++;
                wr_cnt++;
            end
            if (rd_fsm_done) begin
                done_cnt++;
                done_wr = wr_cnt;
            end
            if (reset_n && rd_src_status.rd_state == RD_SRC_WR_FIFO)
                check("rready_tracks_af", 64'(src_mem.rready), 64'(!wr_fifo_if.almost_full));
            if (reset_n && rd_src_status.rd_state == ERROR) begin
                check("err_rready", 64'(src_mem.rready), 64'd1);
                check("err_no_wr", 64'(wr_fifo_if.wr_en), 64'd0);
            end

            @(posedge clk);
            #1;
            if (rst_s) begin
                src_mem.arready = 1'b0;
                src_mem.rvalid  = 1'b0;
                s_beats_left    = 0;
            end else begin
                if (r_hs) begin
                    s_beats_left--;
                    s_data_idx++;
                end
                if (ar_hs) begin
                    src_mem.arready = 1'b0;
                    s_beats_left    = int'(ar_len_hs) + 1;
                end else if (src_mem.arvalid && !src_mem.arready && s_beats_left == 0) begin
                    src_mem.arready = 1'b1;
                end
                if (s_beats_left > 0) begin
                    src_mem.rvalid = 1'b1;
                    src_mem.r.data = {8{64'(s_data_idx)}};
                    src_mem.r.last = (s_beats_left == 1);
                    src_mem.r.resp = (s_data_idx == err_idx) ? RESP_SLVERR : RESP_OKAY;
                end else begin
                    src_mem.rvalid = 1'b0;
                end
            end
        end
    end

    initial begin : af_drv
        wr_fifo_if.almost_full = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            wr_fifo_if.almost_full = af_rand ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    task automatic start_desc(input logic [63:0] addr, input int len);
        wr_cnt     = 0;
        ar_cnt     = 0;
        done_cnt   = 0;
        done_wr    = -1;
        exp_data   = 64'd0;
        s_data_idx = 0;
        descriptor.src_addr                = addr;
        descriptor.length                  = LENGTH_W'(len);
        descriptor.descriptor_control.go   = 1'b1;
        descriptor_fifo_not_empty          = 1'b1;
        @(posedge clk);
        #1;
        descriptor.descriptor_control.go   = 1'b0;
        descriptor_fifo_not_empty          = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_done_seen"}, 64'(done_cnt != 0), 64'd1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check({tag, "_done_once"}, 64'(done_cnt), 64'd1);
        check({tag, "_idle"}, 64'(rd_src_status.rd_state), 64'(IDLE));
        check({tag, "_busy"}, 64'(rd_src_status.busy), 64'd0);
    endtask

    task automatic check_ar(input string tag, input int idx, input logic [63:0] addr, input int len);
        check({tag, "_araddr"}, ar_addr_log[idx], addr);
        check({tag, "_arlen"}, 64'(ar_len_log[idx]), 64'(len));
    endtask

    initial begin : main
        int n;
        descriptor  = '0;
        csr_control = '0;
        wr_fifo_if.not_full = 1'b1;
        wr_cnt = 0; ar_cnt = 0; done_cnt = 0; done_wr = -1; exp_data = 64'd0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_state", 64'(rd_src_status.rd_state), 64'(IDLE));
        check("rst_busy", 64'(rd_src_status.busy), 64'd0);
        check("rst_arvalid", 64'(src_mem.arvalid), 64'd0);
        check("rst_rready", 64'(src_mem.rready), 64'd0);
        check("rst_done", 64'(rd_fsm_done), 64'd0);
        check("rst_stopped", 64'(rd_src_status.stopped_on_error), 64'd0);
        check("rst_rsp_err", 64'(rd_src_status.rd_rsp_err), 64'd0);
        check("rst_cnts", 64'(rd_src_status.valid_cnt | rd_src_status.clk_cnt), 64'd0);
        check("tie_awvalid", 64'(src_mem.awvalid), 64'd0);
        check("tie_wvalid", 64'(src_mem.wvalid), 64'd0);
        check("tie_bready", 64'(src_mem.bready), 64'd1);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel_state", 64'(rd_src_status.rd_state), 64'(IDLE));
        check("rel_arvalid", 64'(src_mem.arvalid), 64'd0);

        // Single short burst
        start_desc(64'h1000, 4);
        wait_done("len4", 200);
        check("len4_ar_cnt", 64'(ar_cnt), 64'd1);
        check_ar("len4", 0, 64'h1000, 3);
        check("len4_wr_cnt", 64'(wr_cnt), 64'd4);
        check("len4_done_beat", 64'(done_wr), 64'd4);
        check("len4_valid_cnt", 64'(rd_src_status.valid_cnt), 64'd4);
        check("len4_clk_cnt", 64'(rd_src_status.clk_cnt), 64'd4);

        // Three bursts, short tail
        start_desc(64'h2000_0000, 600);
        wait_done("len600", 3000);
        check("len600_ar_cnt", 64'(ar_cnt), 64'd3);
        check_ar("len600_b0", 0, 64'h2000_0000, 255);
        check_ar("len600_b1", 1, 64'h2000_4000, 255);
        check_ar("len600_b2", 2, 64'h2000_8000, 87);
        check("len600_wr_cnt", 64'(wr_cnt), 64'd600);
        check("len600_done_beat", 64'(done_wr), 64'd600);
        check("len600_valid_cnt", 64'(rd_src_status.valid_cnt), 64'd600);

        // Exactly one full burst
        start_desc(64'h4000, 256);
        wait_done("len256", 1000);
        check("len256_ar_cnt", 64'(ar_cnt), 64'd1);
        check_ar("len256", 0, 64'h4000, 255);
        check("len256_wr_cnt", 64'(wr_cnt), 64'd256);

        // Address wraps at the top of the address space
        start_desc(64'hFFFF_FFFF_FFFF_C000, 300);
        wait_done("wrap", 1500);
        check("wrap_ar_cnt", 64'(ar_cnt), 64'd2);
        check_ar("wrap_b0", 0, 64'hFFFF_FFFF_FFFF_C000, 255);
        check_ar("wrap_b1", 1, 64'h0, 43);
        check("wrap_wr_cnt", 64'(wr_cnt), 64'd300);

        // Random FIFO backpressure
        af_rand = 1'b1;
        start_desc(64'h8000, 16);
        wait_done("af16", 500);
        af_rand = 1'b0;
        check("af16_ar_cnt", 64'(ar_cnt), 64'd1);
        check_ar("af16", 0, 64'h8000, 15);
        check("af16_wr_cnt", 64'(wr_cnt), 64'd16);
        check("af16_valid_cnt", 64'(rd_src_status.valid_cnt), 64'd16);

        // SLVERR on beat index 2
        err_idx = 2;
        start_desc(64'h9000, 8);
        n = 0;
        while (rd_src_status.rd_state != ERROR && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("err_state", 64'(rd_src_status.rd_state), 64'(ERROR));
        check("err_rsp_err", 64'(rd_src_status.rd_rsp_err), 64'd1);
        check("err_stopped", 64'(rd_src_status.stopped_on_error), 64'd1);
        check("err_busy", 64'(rd_src_status.busy), 64'd1);
        repeat (12) begin
            @(posedge clk);
            #1;
        end
        check("err_state_held", 64'(rd_src_status.rd_state), 64'(ERROR));
        check("err_wr_cnt", 64'(wr_cnt), 64'd2);
        check("err_no_done", 64'(done_cnt), 64'd0);
        csr_control.reset_dispatcher = 1'b1;
        @(posedge clk);
        #1;
        csr_control.reset_dispatcher = 1'b0;
        check("err_cleared_state", 64'(rd_src_status.rd_state), 64'(IDLE));
        check("err_cleared_stopped", 64'(rd_src_status.stopped_on_error), 64'd0);
        err_idx = -1;

        // Reset in the middle of a burst
        start_desc(64'hA000, 256);
        n = 0;
        while (wr_cnt < 100 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("mid_reached_100", 64'(wr_cnt), 64'd100);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid_state", 64'(rd_src_status.rd_state), 64'(IDLE));
        check("mid_arvalid", 64'(src_mem.arvalid), 64'd0);
        check("mid_busy", 64'(rd_src_status.busy), 64'd0);
        check("mid_valid_cnt", 64'(rd_src_status.valid_cnt), 64'd0);
        check("mid_clk_cnt", 64'(rd_src_status.clk_cnt), 64'd0);
        check("mid_wr_cnt", 64'(wr_cnt), 64'd100);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rel_state", 64'(rd_src_status.rd_state), 64'(IDLE));
        check("mid_rel_done", 64'(rd_fsm_done), 64'd0);

        // Zero length: done pulse, no AR
        start_desc(64'hB000, 0);
        check("len0_done", 64'(done_cnt), 64'd1);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        check("len0_done_once", 64'(done_cnt), 64'd1);
        check("len0_ar_cnt", 64'(ar_cnt), 64'd0);
        check("len0_wr_cnt", 64'(wr_cnt), 64'd0);
        check("len0_state", 64'(rd_src_status.rd_state), 64'(IDLE));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
